// File: rtl/model_fetcher_pkg.sv
// Shared types for the model fetcher and its ModelBuffer / transform-stage interfaces.
package model_fetcher_pkg;

  localparam int unsigned MAX_TRIANGLE_COUNT_DEF = 512;
  localparam int unsigned TRI_IDX_W              = $clog2(MAX_TRIANGLE_COUNT_DEF);
  localparam int unsigned COORD_W                = 32;

  typedef struct packed {
    logic [7:0] model_id;
    logic [7:0] instance_id;
  } fetch_cmd_t;

  typedef struct packed {
    logic [7:0] instance_id;
    logic       first;
    logic       last;
  } fetch_meta_t;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_ACTIVE,
    FETCH_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]           model_index;
    logic [TRI_IDX_W-1:0] triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [COORD_W-1:0] v0;
    logic [COORD_W-1:0] v1;
    logic [COORD_W-1:0] v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

endpackage

// File: rtl/model_fetcher.sv
// Walks one stored model triangle-by-triangle: issues sequential ModelBuffer reads and
// forwards returned triangles downstream tagged with instance id and first/last flags.
module model_fetcher
  import model_fetcher_pkg::*;
#(
  parameter int unsigned MAX_TRIANGLE_COUNT = MAX_TRIANGLE_COUNT_DEF,
  parameter int unsigned MAX_OUTSTANDING    = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  fetch_cmd_t     cmd_data,
  output logic           req_valid,
  input  logic           req_ready,
  output modelbuf_read_t req_data,
  input  logic           rsp_valid,
  output logic           rsp_ready,
  input  triangle_t      rsp_data,
  input  triangle_meta_t rsp_meta,
  output logic           tri_valid,
  input  logic           tri_ready,
  output triangle_t      tri_data,
  output fetch_meta_t    tri_meta,
  output logic           busy,
  output logic           overflow_err
);

  localparam int unsigned IDX_W = $clog2(MAX_TRIANGLE_COUNT) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0] IDX_CAP = IDX_W'(MAX_TRIANGLE_COUNT);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  fetch_state_t     state_q, state_d;
  logic [7:0]       model_id_q, model_id_d;
  logic [7:0]       instance_id_q, instance_id_d;
  logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             stop_q, stop_d;
  logic             first_q, first_d;
  logic             overflow_q, overflow_d;

  logic req_hs, rsp_hs, tri_hs, cap_last;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= FETCH_IDLE;
      model_id_q    <= '0;
      instance_id_q <= '0;
      issue_idx_q   <= '0;
      outstanding_q <= '0;
      stop_q        <= 1'b0;
      first_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      model_id_q    <= model_id_d;
      instance_id_q <= instance_id_d;
      issue_idx_q   <= issue_idx_d;
      outstanding_q <= outstanding_d;
      stop_q        <= stop_d;
      first_q       <= first_d;
      overflow_q    <= overflow_d;
    end
  end

  // Next state, handshakes and interface outputs
  always_comb begin
    state_d       = state_q;
    model_id_d    = model_id_q;
    instance_id_d = instance_id_q;
    issue_idx_d   = issue_idx_q;
    outstanding_d = outstanding_q;
    stop_d        = stop_q;
    first_d       = first_q;
    overflow_d    = overflow_q;

    cmd_ready    = 1'b0;
    req_valid    = 1'b0;
    rsp_ready    = 1'b0;
    tri_valid    = 1'b0;
    busy         = (state_q != FETCH_IDLE);
    overflow_err = overflow_q;

    req_data.model_index    = model_id_q;
    req_data.triangle_index = TRI_IDX_W'(issue_idx_q);
    tri_data                = rsp_data;

    // The final capped read is the only one in flight once the cap is reached
    cap_last             = (issue_idx_q == IDX_CAP) && (outstanding_q == OUT_W'(1));
    tri_meta.instance_id = instance_id_q;
    tri_meta.first       = first_q;
    tri_meta.last        = rsp_meta.last || cap_last;

    case (state_q)
      FETCH_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d       = FETCH_ACTIVE;
          model_id_d    = cmd_data.model_id;
          instance_id_d = cmd_data.instance_id;
          issue_idx_d   = '0;
          stop_d        = 1'b0;
          first_d       = 1'b1;
          overflow_d    = 1'b0;
        end
      end
      FETCH_ACTIVE: begin
        req_valid = !stop_q && (outstanding_q < OUT_MAX);
        tri_valid = rsp_valid;
        rsp_ready = tri_ready;
      end
      FETCH_DRAIN: begin
        rsp_ready = 1'b1;
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase

    req_hs = req_valid && req_ready;
    rsp_hs = rsp_valid && rsp_ready;
    tri_hs = tri_valid && tri_ready;

    if (req_hs) begin
      issue_idx_d = issue_idx_q + IDX_W'(1);
    end
    outstanding_d = outstanding_q + OUT_W'(req_hs) - OUT_W'(rsp_hs);

    if (state_q == FETCH_ACTIVE) begin
      if (issue_idx_d == IDX_CAP) begin
        stop_d = 1'b1;
      end
      if (rsp_hs && rsp_meta.last) begin
        stop_d = 1'b1;
      end
      if (tri_hs) begin
        first_d = 1'b0;
        if (tri_meta.last) begin
          if (cap_last && !rsp_meta.last) begin
            overflow_d = 1'b1;
          end
          // Reads issued past the model end still have to be absorbed
          state_d = (outstanding_d == '0) ? FETCH_IDLE : FETCH_DRAIN;
        end
      end
    end

    if ((state_q == FETCH_DRAIN) && (outstanding_d == '0)) begin
      state_d = FETCH_IDLE;
    end
  end

endmodule

// File: tb/tb_model_fetcher.sv
// Scoreboard bench for model_fetcher: a ModelBuffer emulator answers reads in order,
// expected triangles are queued per command and popped by an output monitor.
module tb_model_fetcher;
  import model_fetcher_pkg::*;

  localparam int unsigned CAP    = 8;
  localparam int unsigned MAXO   = 2;
  localparam int unsigned BUDGET = 400;

  typedef struct packed {
    triangle_t   data;
    fetch_meta_t meta;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           cmd_valid, cmd_ready;
  fetch_cmd_t     cmd_data;
  logic           req_valid, req_ready;
  modelbuf_read_t req_data;
  logic           rsp_valid, rsp_ready;
  triangle_t      rsp_data;
  triangle_meta_t rsp_meta;
  logic           tri_valid, tri_ready;
  triangle_t      tri_data;
  fetch_meta_t    tri_meta;
  logic           busy, overflow_err;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned cyc    = 0;
  int unsigned model_len [256];   // 0 means the model never flags last
  modelbuf_read_t mbq[$];
  exp_t           exp_q[$];
  bit             rand_mode = 1'b0;
  int unsigned    req_cnt = 0, max_out = 0, tri_seen = 0, first_cyc = 0, last_cyc = 0;

  model_fetcher #(.MAX_TRIANGLE_COUNT(CAP), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_meta(rsp_meta),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data), .tri_meta(tri_meta),
    .busy(busy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Stored triangle contents, a pure function of (model, index)
  function automatic triangle_t tri_fn(input logic [7:0] m, input logic [TRI_IDX_W-1:0] i);
    triangle_t t;
    t.v0 = {m, 8'h5c, 7'd0, i};
    t.v1 = t.v0 ^ 32'hA5A5_5A5A;
    t.v2 = t.v0 + 32'h1357_9BDF;
    return t;
  endfunction

  // ModelBuffer emulator and random ready generation
  initial begin : env
    bit hs_req, hs_rsp, hs_cmd;
    modelbuf_read_t req_snap;
    req_ready = 1'b1; tri_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = '0; rsp_meta = '0;
    forever begin
      @(negedge clk);
      hs_req   = req_valid && req_ready;
      hs_rsp   = rsp_valid && rsp_ready;
      hs_cmd   = cmd_valid && cmd_ready;
      req_snap = req_data;
      @(posedge clk); #1;
      if (!rstn) begin
        mbq.delete();
      end else begin
        if (hs_cmd) begin req_cnt = 0; max_out = 0; end
        if (hs_rsp && mbq.size() > 0) void'(mbq.pop_front());
        if (hs_req) begin mbq.push_back(req_snap); req_cnt++; end
        if (mbq.size() > max_out) max_out = mbq.size();
      end
      rsp_valid = (mbq.size() > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
      if (mbq.size() > 0) begin
        rsp_data      = tri_fn(mbq[0].model_index, mbq[0].triangle_index);
        rsp_meta.last = (model_len[mbq[0].model_index] != 0) &&
                        (int'(mbq[0].triangle_index) == int'(model_len[mbq[0].model_index]) - 1);
      end else begin
        rsp_data = '0; rsp_meta = '0;
      end
      req_ready = !rand_mode || ($urandom_range(0, 3) != 0);
      tri_ready = !rand_mode || ($urandom_range(0, 1) != 0);
    end
  end

  // Output monitor: every downstream handshake must match the scoreboard head
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && tri_valid && tri_ready) begin
        if (exp_q.size() == 0) begin
          check("tri_unexpected", 128'(tri_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("tri", 128'({tri_data, tri_meta}), 128'(e));
          if (e.meta.first) first_cyc = cyc;
          if (e.meta.last) last_cyc = cyc;
          tri_seen++;
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] mid, input logic [7:0] iid);
    int len = int'(model_len[mid]);
    int n   = (len == 0 || len > int'(CAP)) ? int'(CAP) : len;
    bit ok  = 1'b0;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data             = tri_fn(mid, TRI_IDX_W'(i));
      e.meta.instance_id = iid;
      e.meta.first       = (i == 0);
      e.meta.last        = (i == n - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_data.model_id    = mid;
    cmd_data.instance_id = iid;
    cmd_valid            = 1'b1;
    for (int c = 0; c < int'(BUDGET); c++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check("cmd_accept", 128'(ok), 128'(1));
    if (ok) check("prior_fetch_done", 128'(exp_q.size()), 128'(n));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (ok) check("post_accept_flags", 128'({busy, cmd_ready, overflow_err}), 128'(3'b100));
  endtask

  task automatic wait_idle(input string name, input bit exp_ovf, input int exp_lag, input int exp_reqs);
    bit ok = 1'b0;
    for (int c = 0; c < int'(BUDGET); c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check({name, "_idle"}, 128'({ok, cmd_ready}), 128'(2'b11));
    check({name, "_overflow"}, 128'(overflow_err), 128'(exp_ovf));
    check({name, "_all_out"}, 128'(exp_q.size()), 128'(0));
    check({name, "_drained"}, 128'(mbq.size()), 128'(0));
    check({name, "_max_outstanding"}, 128'(max_out <= MAXO), 128'(1));
    if (exp_lag >= 0) check({name, "_idle_lag"}, 128'(cyc - last_cyc), 128'(exp_lag));
    if (exp_reqs >= 0) check({name, "_reqs"}, 128'(req_cnt), 128'(exp_reqs));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base;
    bit ok;
    logic [7:0] mid;
    rstn = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
    for (int i = 0; i < 256; i++) model_len[i] = 3;
    model_len[3] = 4; model_len[1] = 1; model_len[5] = 7; model_len[9] = 0;
    model_len[6] = 6; model_len[2] = 3; model_len[4] = 5;
    #3 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 128'({busy, overflow_err, req_valid, tri_valid, cmd_ready}), 128'(5'b00001));
    #2 rstn = 1'b1;

    // 4-triangle model at full rate
    send_cmd(8'd3, 8'd7);
    wait_idle("t1", 1'b0, 2, 5);
    check("t1_burst_span", 128'(last_cyc - first_cyc), 128'(3));

    // single-triangle model, speculative read dropped
    send_cmd(8'd1, 8'd8);
    wait_idle("t2", 1'b0, 2, 2);

    // random backpressure, then random models including never-last ones
    rand_mode = 1'b1;
    send_cmd(8'd5, 8'($urandom_range(0, 255)));
    wait_idle("t3", 1'b0, -1, -1);
    for (int k = 0; k < 10; k++) begin
      mid = 8'($urandom_range(10, 40));
      model_len[mid] = $urandom_range(0, CAP - 1);
      send_cmd(mid, 8'($urandom_range(0, 255)));
      wait_idle("rand", model_len[mid] == 0, -1, -1);
    end
    rand_mode = 1'b0;

    // cap-forced last and overflow clear on next accept
    send_cmd(8'd9, 8'd3);
    wait_idle("t4", 1'b1, -1, int'(CAP));
    send_cmd(8'd2, 8'd4);
    wait_idle("t4b", 1'b0, 2, 4);

    // reset in the middle of a fetch
    base = int'(tri_seen);
    ok = 1'b0;
    send_cmd(8'd6, 8'd11);
    for (int c = 0; c < int'(BUDGET); c++) begin
      @(negedge clk); #2;
      if (int'(tri_seen) >= base + 2) begin ok = 1'b1; break; end
    end
    check("t5_two_tris", 128'(ok), 128'(1));
    rstn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("t5_reset_outputs", 128'({busy, overflow_err, req_valid, tri_valid, cmd_ready}), 128'(5'b00001));
    #2 rstn = 1'b1;
    send_cmd(8'd2, 8'd12);
    wait_idle("t5_restart", 1'b0, 2, 4);

    // back-to-back commands with cmd_valid held
    send_cmd(8'd4, 8'd20);
    send_cmd(8'd3, 8'd21);
    wait_idle("t6", 1'b0, 2, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
